uart_rx_controller: RTL and testbench

- Receive-side sequencer for the UART link; consumes the 16x-oversampling `sample_ENABLE` pulse from the receive baud controller.
- Detects the start bit and samples data, parity and stop bits at mid-bit.
- Presents each received byte with a one-cycle valid strobe plus parity/framing error flags.
- Sits between the RxD pin and the decoding logic; the baud controller is instantiated alongside it, not inside it.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_controller.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit slice: FSM state
// encoding, oversampling constants and the baud-rate selector encoding
// used by the baud controllers.
package uart_pkg;

    // Receiver sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // sample_ENABLE pulses per bit period and the mid-bit sample index
    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_POINT = OVERSAMPLE / 2 - 1;

    // Baud-rate selector shared with the transmit/receive baud controllers
    typedef enum logic [1:0] {
        BAUD_9600   = 2'd0,
        BAUD_19200  = 2'd1,
        BAUD_57600  = 2'd2,
        BAUD_115200 = 2'd3
    } baud_select_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RxD line. Both stages reset
// to 1 so the line reads as idle while reset is active.
module uart_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_reg;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_reg <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta_reg <= async_in;
            sync_out <= meta_reg;
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer. Detects the start bit on the synchronized RxD
// line, samples data/parity/stop bits at mid-bit using the 16x sample
// tick, and presents each byte with a one-clock valid strobe plus
// parity (even) and framing error flags.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3
// majority of samples at SP-1, SP, SP+1 and every decision moves to SP+1.
module uart_rx_controller #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_ENABLE,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR
);

    import uart_pkg::*;

    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int SPL = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int DP  = SPL + 1;
`else
    localparam int DP  = SPL;
`endif

    localparam logic [TW-1:0] DP_T   = TW'(DP);
    localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 bit_value;
    rx_state_t            state_reg;
    logic [TW-1:0]        tick_cnt_reg;
    logic [BW-1:0]        bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_reg;

    uart_rx_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (RxD),
        .sync_out (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] SPM1_T = TW'(SPL - 1);
    localparam logic [TW-1:0] SP_T   = TW'(SPL);

    logic maj_a_reg;
    logic maj_b_reg;

    // Capture the two samples preceding the decision tick
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            maj_a_reg <= 1'b1;
            maj_b_reg <= 1'b1;
        end else if (sample_ENABLE) begin
            if (tick_cnt_reg == SPM1_T)
                maj_a_reg <= rx_s;
            if (tick_cnt_reg == SP_T)
                maj_b_reg <= rx_s;
        end
    end

    assign bit_value = (maj_a_reg & maj_b_reg) | (maj_a_reg & rx_s) | (maj_b_reg & rx_s);
`else
    assign bit_value = rx_s;
`endif

    // Frame sequencer with registered byte/flag outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            Rx_DATA      <= '0;
            Rx_VALID     <= 1'b0;
            Rx_PERROR    <= 1'b0;
            Rx_FERROR    <= 1'b0;
        end else begin
            Rx_VALID <= 1'b0;
            if (!Rx_EN) begin
                // Disabled: drop any partial frame, leave outputs untouched
                state_reg    <= IDLE;
                tick_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
            end else if (sample_ENABLE) begin
                case (state_reg)
                    IDLE: begin
                        // The detecting tick is index 0 of the start window
                        if (!rx_s) begin
                            state_reg    <= START;
                            tick_cnt_reg <= TW'(1);
                        end
                    end
                    START: begin
                        if (tick_cnt_reg == DP_T && bit_value) begin
                            state_reg    <= IDLE;
                            tick_cnt_reg <= '0;
                        end else if (tick_cnt_reg == LAST_T) begin
                            state_reg    <= DATA;
                            tick_cnt_reg <= '0;
                            bit_cnt_reg  <= '0;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt_reg == DP_T)
                            shift_reg[bit_cnt_reg] <= bit_value;
                        if (tick_cnt_reg == LAST_T) begin
                            tick_cnt_reg <= '0;
                            if (bit_cnt_reg == BLAST) begin
                                state_reg   <= PARITY;
                                bit_cnt_reg <= '0;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (tick_cnt_reg == DP_T)
                            parity_reg <= bit_value;
                        if (tick_cnt_reg == LAST_T) begin
                            state_reg    <= STOP;
                            tick_cnt_reg <= '0;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    STOP: begin
                        // Finish at mid stop bit so the next start edge is caught
                        if (tick_cnt_reg == DP_T) begin
                            Rx_DATA      <= shift_reg;
                            Rx_PERROR    <= parity_reg ^ (^shift_reg);
                            Rx_FERROR    <= ~bit_value;
                            Rx_VALID     <= 1'b1;
                            state_reg    <= IDLE;
                            tick_cnt_reg <= '0;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg    <= IDLE;
                        tick_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Scoreboard bench for uart_rx_controller: frames are serialized tick by
// tick on RxD, the expected byte/flags/completion tick are queued when a
// frame is launched, and popped whenever Rx_VALID is seen.
module tb_uart_rx_controller;

`ifdef UART_RX_MAJORITY_EN
    localparam int DP = 8;
`else
    localparam int DP = 7;
`endif

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         tick;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sample_ENABLE = 1'b0;
    logic       Rx_EN = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    int   checks = 0;
    int   errors = 0;
    int   tick_num = 0;
    int   valid_count = 0;
    int   div_cnt = 0;
    exp_t exp_q[$];

    uart_rx_controller dut (
        .clock         (clock),
        .reset         (reset),
        .sample_ENABLE (sample_ENABLE),
        .Rx_EN         (Rx_EN),
        .RxD           (RxD),
        .Rx_DATA       (Rx_DATA),
        .Rx_VALID      (Rx_VALID),
        .Rx_PERROR     (Rx_PERROR),
        .Rx_FERROR     (Rx_FERROR)
    );

    always #5 clock = ~clock;

    // One sample tick every fourth clock, changed away from the active edge
    always @(negedge clock) begin
        div_cnt = (div_cnt == 3) ? 0 : div_cnt + 1;
        sample_ENABLE = (div_cnt == 3);
    end

    always @(posedge clock) begin
        if (sample_ENABLE)
            tick_num <= tick_num + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid strobe must match the oldest queued frame
    always @(negedge clock) begin
        if (reset && Rx_VALID) begin
            exp_t e;
            valid_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("frame: data=0x%02h perr=%0b ferr=%0b tick=%0d (exp 0x%02h %0b %0b %0d)",
                         Rx_DATA, Rx_PERROR, Rx_FERROR, tick_num, e.data, e.perr, e.ferr, e.tick);
                check("rx_data", 32'(Rx_DATA), 32'(e.data));
                check("rx_perror", 32'(Rx_PERROR), 32'(e.perr));
                check("rx_ferror", 32'(Rx_FERROR), 32'(e.ferr));
                check("valid_tick", 32'(tick_num), 32'(e.tick));
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clock);
            while (!sample_ENABLE) @(posedge clock);
        end
    endtask

    // Serialize one frame; abort_at > 0 stops after that many ticks and
    // queues nothing; spike_at >= 0 forces one low tick at that offset.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                              input int stop_ticks, input int abort_at, input int spike_at);
        logic [10:0] bits;
        int          elapsed;
        int          len;
        exp_t        e;
        bits    = {stop, p, d, 1'b0};
        elapsed = 0;
        #1;
        if (abort_at == 0) begin
            e.data = d;
            e.perr = p ^ (^d);
            e.ferr = ~stop;
            e.tick = tick_num + 1 + 160 + DP;
            exp_q.push_back(e);
        end
        for (int b = 0; b < 11; b++) begin
            len = (b == 10) ? stop_ticks : 16;
            for (int t = 0; t < len; t++) begin
                if (abort_at != 0 && elapsed == abort_at)
                    return;
                RxD = (elapsed == spike_at) ? 1'b0 : bits[b];
                wait_ticks(1);
                #1;
                elapsed++;
            end
        end
        RxD = 1'b1;
    endtask

    initial begin
        int vc;

        // Reset state
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("reset_data", 32'(Rx_DATA), 32'h0);
        check("reset_valid", 32'(Rx_VALID), 32'h0);
        check("reset_perror", 32'(Rx_PERROR), 32'h0);
        check("reset_ferror", 32'(Rx_FERROR), 32'h0);
        reset = 1'b1;
        Rx_EN = 1'b1;
        wait_ticks(20);

        // Clean frame, parity error frame, then a good frame clearing it
        send_frame(8'hA5, 1'b0, 1'b1, 16, 0, -1);
        wait_ticks(20);
        send_frame(8'h3C, 1'b1, 1'b1, 16, 0, -1);
        wait_ticks(20);
        send_frame(8'h01, 1'b1, 1'b1, 16, 0, -1);
        wait_ticks(20);

        // Framing error; short low stop bit so the following start is false
        send_frame(8'hFF, 1'b0, 1'b0, 9, 0, -1);
        wait_ticks(30);
        @(negedge clock);
        check("ferror_hold", 32'(Rx_FERROR), 32'h1);

        // Idle-line glitch must never produce a frame
        vc = valid_count;
        #1;
        RxD = 1'b0;
        wait_ticks(4);
        #1;
        RxD = 1'b1;
        wait_ticks(200);
        check("glitch_no_valid", 32'(valid_count), 32'(vc));

        // Enable dropped mid data bit 3, then a full frame after re-enable
        send_frame(8'h55, 1'b0, 1'b1, 16, 68, -1);
        Rx_EN = 1'b0;
        RxD = 1'b1;
        wait_ticks(5);
        @(negedge clock);
        check("en_drop_data_hold", 32'(Rx_DATA), 32'hFF);
        Rx_EN = 1'b1;
        wait_ticks(20);
        vc = valid_count;
        send_frame(8'h12, 1'b0, 1'b1, 16, 0, -1);
        wait_ticks(20);
        check("en_single_valid", 32'(valid_count - vc), 32'd1);

        // Back-to-back frames with short stop bits, reset during a third
        send_frame(8'h81, 1'b0, 1'b1, 10, 0, -1);
        send_frame(8'h7E, 1'b0, 1'b1, 10, 0, -1);
        send_frame(8'h33, 1'b0, 1'b1, 16, 40, -1);
        check("b2b_both_seen", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        RxD = 1'b1;
        @(negedge clock);
        check("midreset_data", 32'(Rx_DATA), 32'h0);
        check("midreset_valid", 32'(Rx_VALID), 32'h0);
        repeat (3) @(posedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("postreset_data", 32'(Rx_DATA), 32'h0);
        check("postreset_perror", 32'(Rx_PERROR), 32'h0);
        check("postreset_ferror", 32'(Rx_FERROR), 32'h0);
        wait_ticks(20);

`ifdef UART_RX_MAJORITY_EN
        // One-tick low spike at the centre of data bit 0 is voted out
        send_frame(8'hFF, 1'b0, 1'b1, 16, 0, 16 + 7);
        wait_ticks(20);
`endif

        // Every launched frame must have been seen
        for (int i = 0; i < 400 && exp_q.size() != 0; i++)
            wait_ticks(1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
